decode_scan_ctrl: RTL and testbench

Sequencer that drives the select and enable inputs of the 4→16 decoder tree built from enabled 2→4 decoders. It steps a 4-bit slot address through the slots set in a run-time mask. Before each slot it blanks the decoders by holding `enable` high, then releases them for a programmed dwell time. It sits directly upstream of the decoder tree and is the only writer of its `A`/`B`/`enable` inputs.

---
 rtl/decode_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_decode_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_scan_ctrl.sv
// Slot sequencer for the 4->16 decoder tree: steps addr through the set bits of
// mask, blanking the decoders (enable=1) before each slot and showing it for DWELL cycles.
module decode_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] mask,
  output logic [3:0]  addr,
  output logic        enable,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  // Reload values for the shared down-counter; BLANK_LD is unused when BLANK is 0.
  localparam logic [15:0] BLANK_LD = (BLANK > 0) ? 16'(BLANK - 1) : 16'd0;
  localparam logic [15:0] DWELL_LD = 16'(DWELL - 1);
  localparam bit          NO_BLANK = (BLANK == 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  addr_q, addr_d;
  logic        enable_q, enable_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;

  logic [31:0] mask_dbl;
  logic [4:0]  rot_shift;
  logic [15:0] mask_rot;
  logic [3:0]  first_addr;
  logic [3:0]  next_addr;
  logic        next_wraps;

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

  // Rotating the doubled mask puts slot addr+1 at bit 0, so the lowest set bit
  // of the rotated word is the distance to the next participating slot.
  always_comb begin
    mask_dbl   = {mask, mask};
    rot_shift  = {1'b0, addr_q} + 5'd1;
    mask_rot   = 16'(mask_dbl >> rot_shift);
    first_addr = lowest_set(mask);
    next_addr  = addr_q + 4'd1 + lowest_set(mask_rot);
    next_wraps = (next_addr <= addr_q);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run && (mask != 16'd0)) begin
          addr_d = first_addr;
          if (NO_BLANK) begin
            state_d = S_SHOW;
            cnt_d   = DWELL_LD;
          end else begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LD;
          end
        end
      end

      S_BLANK: begin
        if (cnt_q == 16'd0) begin
          state_d = S_SHOW;
          cnt_d   = DWELL_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_SHOW: begin
        if (cnt_q == 16'd0) begin
          if (!run || (mask == 16'd0)) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end else begin
            addr_d       = next_addr;
            frame_done_d = next_wraps;
            if (NO_BLANK) begin
              state_d = S_SHOW;
              cnt_d   = DWELL_LD;
            end else begin
              state_d = S_BLANK;
              cnt_d   = BLANK_LD;
            end
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    enable_d = (state_d != S_SHOW);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      addr_q       <= 4'd0;
      enable_q     <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign addr       = addr_q;
  assign enable     = enable_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_decode_scan_ctrl.sv
// Scoreboard bench for decode_scan_ctrl: stimulus pushes per-cycle expected
// outputs, monitors pop and compare one entry per clock.
module tb_decode_scan_ctrl;

  typedef struct packed {
    logic [3:0] addr;
    logic       en;
    logic       fd;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: DWELL=4, BLANK=2 ; dut1: DWELL=1, BLANK=0
  logic        rst0, run0, rst1, run1;
  logic [15:0] mask0, mask1;
  logic [3:0]  addr0, addr1;
  logic        en0, en1, fd0, fd1, busy0, busy1;

  decode_scan_ctrl #(.DWELL(4), .BLANK(2)) dut0 (
    .clk(clk), .reset(rst0), .run(run0), .mask(mask0),
    .addr(addr0), .enable(en0), .frame_done(fd0), .busy(busy0)
  );

  decode_scan_ctrl #(.DWELL(1), .BLANK(0)) dut1 (
    .clk(clk), .reset(rst1), .run(run1), .mask(mask1),
    .addr(addr1), .enable(en1), .frame_done(fd1), .busy(busy1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [3:0] a, input logic e, input logic f, input logic b);
    exp_t r;
    r.addr = a;
    r.en   = e;
    r.fd   = f;
    r.busy = b;
    return r;
  endfunction

  task automatic check(input string tag, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got addr=%0d en=%b fd=%b busy=%b, want addr=%0d en=%b fd=%b busy=%b",
               tag, $time, act.addr, act.en, act.fd, act.busy, exp.addr, exp.en, exp.fd, exp.busy);
    end else begin
      $display("ok   %s t=%0t: addr=%0d en=%b fd=%b busy=%b",
               tag, $time, act.addr, act.en, act.fd, act.busy);
    end
  endtask

  // Monitors: one scoreboard entry per clock while entries are pending.
  exp_t e0, e1;
  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check("dut0", mk(addr0, en0, fd0, busy0), e0);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("dut1", mk(addr1, en1, fd1, busy1), e1);
    end
  end

  // One dut0 slot: 2 blank cycles (frame_done on the first if wrapped) then 4 show cycles.
  task automatic push_slot0(input logic [3:0] a, input logic wrapped);
    q0.push_back(mk(a, 1'b1, wrapped, 1'b1));
    q0.push_back(mk(a, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) q0.push_back(mk(a, 1'b0, 1'b0, 1'b1));
  endtask

  // Returns at posedge+2 once the chosen queue has been consumed.
  task automatic wait_drain(input bit which);
    for (int i = 0; i < 400; i++) begin
      if ((which == 1'b0 && q0.size() == 0) || (which == 1'b1 && q1.size() == 0)) return;
      @(posedge clk);
      #2;
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout dut%0d: %0d entries left, want 0", which,
             (which == 1'b0) ? q0.size() : q1.size());
    if (which == 1'b0) q0.delete();
    else q1.delete();
  endtask

  task automatic end_test0(input string tag);
    rst0 = 1'b1;
    run0 = 1'b0;
    #1;
    check(tag, mk(addr0, en0, fd0, busy0), mk(4'd0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0  = 1'b1; run0 = 1'b0; mask0 = 16'h0000;
    rst1  = 1'b1; run1 = 1'b0; mask1 = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset0", mk(addr0, en0, fd0, busy0), mk(4'd0, 1'b1, 1'b0, 1'b0));
    check("reset1", mk(addr1, en1, fd1, busy1), mk(4'd0, 1'b1, 1'b0, 1'b0));
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Full mask: 0..15 then back to 0 with frame_done 96 cycles after start.
    run0 = 1'b1; mask0 = 16'hFFFF;
    for (int s = 0; s < 16; s++) push_slot0(4'(s), 1'b0);
    push_slot0(4'd0, 1'b1);
    wait_drain(1'b0);
    end_test0("rst_after_full");

    // Two end slots: frame_done only on 15->0.
    run0 = 1'b1; mask0 = 16'h8001;
    push_slot0(4'd0, 1'b0);
    push_slot0(4'd15, 1'b0);
    push_slot0(4'd0, 1'b1);
    push_slot0(4'd15, 1'b0);
    push_slot0(4'd0, 1'b1);
    wait_drain(1'b0);
    end_test0("rst_after_8001");

    // Single slot: reselected every period with frame_done each time.
    run0 = 1'b1; mask0 = 16'h0020;
    push_slot0(4'd5, 1'b0);
    for (int i = 0; i < 3; i++) push_slot0(4'd5, 1'b1);
    wait_drain(1'b0);
    end_test0("rst_after_0020");

    // run dropped in the 2nd show cycle of slot 3, then restart at slot 1.
    run0 = 1'b1; mask0 = 16'h000A;
    push_slot0(4'd1, 1'b0);
    q0.push_back(mk(4'd3, 1'b1, 1'b0, 1'b1));
    q0.push_back(mk(4'd3, 1'b1, 1'b0, 1'b1));
    q0.push_back(mk(4'd3, 1'b0, 1'b0, 1'b1));
    wait_drain(1'b0);
    for (int i = 0; i < 3; i++) q0.push_back(mk(4'd3, 1'b0, 1'b0, 1'b1));
    q0.push_back(mk(4'd3, 1'b1, 1'b0, 1'b0));
    q0.push_back(mk(4'd3, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    run0 = 1'b0;
    wait_drain(1'b0);
    @(negedge clk);
    run0 = 1'b1;
    push_slot0(4'd1, 1'b0);
    wait_drain(1'b0);
    end_test0("rst_after_stop");

    // Reset mid-show of slot 1: outputs clear before the next edge, then restart.
    run0 = 1'b1; mask0 = 16'hFFFF;
    push_slot0(4'd0, 1'b0);
    q0.push_back(mk(4'd1, 1'b1, 1'b0, 1'b1));
    q0.push_back(mk(4'd1, 1'b1, 1'b0, 1'b1));
    q0.push_back(mk(4'd1, 1'b0, 1'b0, 1'b1));
    wait_drain(1'b0);
    #1;
    rst0 = 1'b1;
    #1;
    check("rst_async", mk(addr0, en0, fd0, busy0), mk(4'd0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst0 = 1'b0;
    push_slot0(4'd0, 1'b0);
    q0.push_back(mk(4'd1, 1'b1, 1'b0, 1'b1));
    wait_drain(1'b0);
    end_test0("rst_final0");

    // No blanking, one-cycle dwell: addr changes every cycle, mask->0 stops.
    run1 = 1'b1; mask1 = 16'h000F;
    q1.push_back(mk(4'd0, 1'b0, 1'b0, 1'b1));
    q1.push_back(mk(4'd1, 1'b0, 1'b0, 1'b1));
    q1.push_back(mk(4'd2, 1'b0, 1'b0, 1'b1));
    q1.push_back(mk(4'd3, 1'b0, 1'b0, 1'b1));
    q1.push_back(mk(4'd0, 1'b0, 1'b1, 1'b1));
    q1.push_back(mk(4'd1, 1'b0, 1'b0, 1'b1));
    q1.push_back(mk(4'd2, 1'b0, 1'b0, 1'b1));
    wait_drain(1'b1);
    mask1 = 16'h0000;
    q1.push_back(mk(4'd2, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(4'd2, 1'b1, 1'b0, 1'b0));
    wait_drain(1'b1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
